// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS core: ALU operation codes and
// forwarding-select encodings used by the ID/EX stage and the forwarding unit.
package mips_pkg;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_ADD = 4'b0010,
    ALU_NOR = 4'b0011,
    ALU_XOR = 4'b0100,
    ALU_SLL = 4'b0101,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_SRL = 4'b1000,
    ALU_SRA = 4'b1001
  } alu_op_t;

  typedef enum logic [1:0] {
    FWD_NONE  = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_t;

endpackage

// File: rtl/forwarding_unit.sv
// Combinational forwarding select for two source registers against the
// EX/MEM and MEM/WB write ports; the nearer (EX/MEM) producer wins.
module forwarding_unit
  import mips_pkg::*;
#(
  parameter int N_BITS_REG = 5
) (
  input  logic [N_BITS_REG-1:0] i_rs_addr,
  input  logic [N_BITS_REG-1:0] i_rt_addr,
  input  logic                  i_exmem_reg_write,
  input  logic [N_BITS_REG-1:0] i_exmem_rd,
  input  logic                  i_memwb_reg_write,
  input  logic [N_BITS_REG-1:0] i_memwb_rd,
  output fwd_sel_t              o_fwd_a,
  output fwd_sel_t              o_fwd_b
);

  // Register 0 is hard-wired to zero, so a write to it never forwards.
  function automatic fwd_sel_t fwd_select(input logic [N_BITS_REG-1:0] src);
    fwd_sel_t sel;
    if (i_exmem_reg_write && (i_exmem_rd != '0) && (i_exmem_rd == src)) begin
      sel = FWD_EXMEM;
    end else if (i_memwb_reg_write && (i_memwb_rd != '0) && (i_memwb_rd == src)) begin
      sel = FWD_MEMWB;
    end else begin
      sel = FWD_NONE;
    end
    return sel;
  endfunction

  // Per-operand select from the stored source addresses.
  always_comb begin
    o_fwd_a = fwd_select(i_rs_addr);
    o_fwd_b = fwd_select(i_rt_addr);
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, ALU operand selection,
// load-use hazard detection, stall (hold with forwarded-data refresh) and flush.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int N_BITS         = 32,
  parameter int N_BITS_CONTROL = 4,
  parameter int N_BITS_REG     = 5
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_stall,
  input  logic                      i_flush,
  input  logic                      i_valid,
  input  logic [N_BITS-1:0]         i_rs_data,
  input  logic [N_BITS-1:0]         i_rt_data,
  input  logic [N_BITS-1:0]         i_imm,
  input  logic [4:0]                i_shamt,
  input  logic [N_BITS_REG-1:0]     i_rs_addr,
  input  logic [N_BITS_REG-1:0]     i_rt_addr,
  input  logic [N_BITS_REG-1:0]     i_rd_addr,
  input  logic [N_BITS_CONTROL-1:0] i_alu_ctrl,
  input  logic                      i_alu_src,
  input  logic                      i_shift_src,
  input  logic                      i_reg_dst,
  input  logic                      i_reg_write,
  input  logic                      i_mem_read,
  input  logic                      i_mem_write,
  input  logic                      i_mem_to_reg,
  input  logic                      i_exmem_reg_write,
  input  logic [N_BITS_REG-1:0]     i_exmem_rd,
  input  logic [N_BITS-1:0]         i_exmem_data,
  input  logic                      i_memwb_reg_write,
  input  logic [N_BITS_REG-1:0]     i_memwb_rd,
  input  logic [N_BITS-1:0]         i_memwb_data,
  output logic [N_BITS-1:0]         o_dato_A,
  output logic [N_BITS-1:0]         o_dato_B,
  output logic [N_BITS_CONTROL-1:0] o_alu_ctrl,
  output logic [N_BITS-1:0]         o_store_data,
  output logic [N_BITS_REG-1:0]     o_write_reg,
  output logic                      o_reg_write,
  output logic                      o_mem_read,
  output logic                      o_mem_write,
  output logic                      o_mem_to_reg,
  output logic                      o_valid,
  output logic [1:0]                o_fwd_a,
  output logic [1:0]                o_fwd_b,
  output logic                      o_load_use_hazard
);

  typedef struct packed {
    logic                      valid;
    logic [N_BITS-1:0]         rs_data;
    logic [N_BITS-1:0]         rt_data;
    logic [N_BITS-1:0]         imm;
    logic [4:0]                shamt;
    logic [N_BITS_REG-1:0]     rs_addr;
    logic [N_BITS_REG-1:0]     rt_addr;
    logic [N_BITS_REG-1:0]     write_reg;
    logic [N_BITS_CONTROL-1:0] alu_ctrl;
    logic                      alu_src;
    logic                      shift_src;
    logic                      reg_write;
    logic                      mem_read;
    logic                      mem_write;
    logic                      mem_to_reg;
  } stage_t;

  stage_t            stage_r;
  fwd_sel_t          fwd_a_s;
  fwd_sel_t          fwd_b_s;
  logic [N_BITS-1:0] fwd_rs_s;
  logic [N_BITS-1:0] fwd_rt_s;

  forwarding_unit #(
    .N_BITS_REG (N_BITS_REG)
  ) u_forwarding_unit (
    .i_rs_addr         (stage_r.rs_addr),
    .i_rt_addr         (stage_r.rt_addr),
    .i_exmem_reg_write (i_exmem_reg_write),
    .i_exmem_rd        (i_exmem_rd),
    .i_memwb_reg_write (i_memwb_reg_write),
    .i_memwb_rd        (i_memwb_rd),
    .o_fwd_a           (fwd_a_s),
    .o_fwd_b           (fwd_b_s)
  );

  // Forwarded source values selected from the stored regfile data or a producer.
  always_comb begin
    case (fwd_a_s)
      FWD_EXMEM: fwd_rs_s = i_exmem_data;
      FWD_MEMWB: fwd_rs_s = i_memwb_data;
      default:   fwd_rs_s = stage_r.rs_data;
    endcase
    case (fwd_b_s)
      FWD_EXMEM: fwd_rt_s = i_exmem_data;
      FWD_MEMWB: fwd_rt_s = i_memwb_data;
      default:   fwd_rt_s = stage_r.rt_data;
    endcase
  end

  // ALU operand selection; shifts take the value from rt and the amount from shamt.
  always_comb begin
    if (stage_r.shift_src) begin
      o_dato_A = fwd_rt_s;
      o_dato_B = {{(N_BITS-5){1'b0}}, stage_r.shamt};
    end else begin
      o_dato_A = fwd_rs_s;
      if (stage_r.alu_src) begin
        o_dato_B = stage_r.imm;
      end else begin
        o_dato_B = fwd_rt_s;
      end
    end
  end

  // Stage register: flush beats stall beats load. A stall refreshes the data
  // fields with forwarded values so they outlive a producer that retires.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stage_r <= '0;
    end else if (i_flush) begin
      stage_r <= '0;
    end else if (i_stall) begin
      stage_r.rs_data <= fwd_rs_s;
      stage_r.rt_data <= fwd_rt_s;
    end else begin
      stage_r.valid      <= i_valid;
      stage_r.rs_data    <= i_rs_data;
      stage_r.rt_data    <= i_rt_data;
      stage_r.imm        <= i_imm;
      stage_r.shamt      <= i_shamt;
      stage_r.rs_addr    <= i_rs_addr;
      stage_r.rt_addr    <= i_rt_addr;
      stage_r.write_reg  <= i_reg_dst ? i_rd_addr : i_rt_addr;
      stage_r.alu_ctrl   <= i_alu_ctrl;
      stage_r.alu_src    <= i_alu_src;
      stage_r.shift_src  <= i_shift_src;
      stage_r.reg_write  <= i_reg_write;
      stage_r.mem_read   <= i_mem_read;
      stage_r.mem_write  <= i_mem_write;
      stage_r.mem_to_reg <= i_mem_to_reg;
    end
  end

  assign o_alu_ctrl   = stage_r.alu_ctrl;
  assign o_store_data = fwd_rt_s;
  assign o_write_reg  = stage_r.write_reg;
  assign o_reg_write  = stage_r.reg_write;
  assign o_mem_read   = stage_r.mem_read;
  assign o_mem_write  = stage_r.mem_write;
  assign o_mem_to_reg = stage_r.mem_to_reg;
  assign o_valid      = stage_r.valid;
  assign o_fwd_a      = fwd_a_s;
  assign o_fwd_b      = fwd_b_s;

  // Conservative: compares against both ID indices whether or not rt is a source.
  assign o_load_use_hazard = stage_r.valid && stage_r.mem_read &&
                             (stage_r.write_reg != '0) &&
                             ((stage_r.write_reg == i_rs_addr) ||
                              (stage_r.write_reg == i_rt_addr));

endmodule
